// File: rtl/dac_therm_drv.sv
`default_nettype none
// ============================================================================
// Module   : dac_therm_drv
// Purpose  : Binary-to-thermometer driver for a unit-element DAC. Each
//            accepted code is registered, expanded into a unary element-select
//            mask and presented on Y with a fixed two-register latency.
//            With DAC_THERM_DWA_EN defined, the mask is rotated through the
//            element array (data-weighted averaging). This spreads element
//            mismatch over time.
// Ports    : clk      - clock, all state changes on the rising edge
//            rst      - synchronous reset, active-high
//            b        - binary code, 0..NELEM
//            b_valid  - code on b is accepted this cycle
//            Y        - element selects, Y[i]=1 turns element i on
//            y_valid  - Y was updated this cycle from an accepted code
//            ptr      - rotation pointer, 0..NELEM-1 (observation only)
// Macro    : DAC_THERM_DWA_EN - enables the rotating mask and pointer register.
//            When undefined, Y is a plain thermometer mask and ptr is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dac_therm_drv #(
    parameter int NBITS    = 4,
    parameter int RST_CODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NBITS-1:0]        b,
    input  logic                    b_valid,
    output logic [(1<<NBITS)-2:0]   Y,
    output logic                    y_valid,
    output logic [NBITS-1:0]        ptr
);

    // The element count follows from the code width and cannot be set on its own.
    localparam int NELEM = (1 << NBITS) - 1;

    // Plain thermometer expansion: element i is on when i < code.
    function automatic logic [NELEM-1:0] therm(input logic [NBITS-1:0] code);
        logic [NELEM-1:0] m;
        m = '0;
        for (int i = 0; i < NELEM; i++) begin
            m[i] = ((NBITS+1)'(i) < {1'b0, code});
        end
        return m;
    endfunction

    localparam logic [NELEM-1:0] c_rst_mask = therm(NBITS'(RST_CODE));

    // Stage 1: capture the accepted code.
    logic [NBITS-1:0] r_code;
    logic             r_v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_code <= '0;
        end else begin
            r_v1 <= b_valid;
            if (b_valid) begin
                r_code <= b;
            end
        end
    end

    // Mask for the code currently held in stage 1.
    logic [NELEM-1:0] w_mask;

`ifdef DAC_THERM_DWA_EN
    localparam logic [NBITS:0] c_nelem = (NBITS+1)'(NELEM);

    // Rotated mask: element i is on when its distance from the pointer,
    // measured upward modulo NELEM, is below the code.
    function automatic logic [NELEM-1:0] rot_mask(input logic [NBITS-1:0] code,
                                                  input logic [NBITS-1:0] p);
        logic [NELEM-1:0] m;
        logic [NBITS:0]   off;
        m = '0;
        for (int i = 0; i < NELEM; i++) begin
            if (NBITS'(i) >= p) begin
                off = (NBITS+1)'(i) - {1'b0, p};
            end else begin
                off = (NBITS+1)'(i) + c_nelem - {1'b0, p};
            end
            m[i] = (off < {1'b0, code});
        end
        return m;
    endfunction

    logic [NBITS-1:0] r_ptr;
    logic [NBITS:0]   w_sum;
    logic [NBITS-1:0] w_ptr_next;

    // Pointer advances by the code modulo NELEM. A full-scale code wraps
    // exactly once and so leaves the pointer where it was.
    always_comb begin
        w_sum      = {1'b0, r_ptr} + {1'b0, r_code};
        w_ptr_next = w_sum[NBITS-1:0];
        if (w_sum >= c_nelem) begin
            w_ptr_next = NBITS'(w_sum - c_nelem);
        end
        w_mask = rot_mask(r_code, r_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_v1) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign ptr = r_ptr;
`else
    always_comb begin
        w_mask = therm(r_code);
    end

    assign ptr = '0;
`endif

    // Stage 2: registered element selects, so b has no combinational path to Y.
    logic [NELEM-1:0] r_y;
    logic             r_y_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= c_rst_mask;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= r_v1;
            if (r_v1) begin
                r_y <= w_mask;
            end
        end
    end

    assign Y       = r_y;
    assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_dac_therm_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_therm_drv
// Purpose  : Directed self-checking bench for dac_therm_drv. Two instances
//            share stimulus: one with RST_CODE=0 and one with RST_CODE=8.
//            Expectations follow the DAC_THERM_DWA_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_therm_drv;

`ifdef DAC_THERM_DWA_EN
    localparam bit c_dwa = 1'b1;
`else
    localparam bit c_dwa = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  b;
    logic        b_valid;
    logic [14:0] y0;
    logic        yv0;
    logic [3:0]  p0;
    logic [14:0] y8;
    logic        yv8;
    logic [3:0]  p8;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  m_ptr;
    logic [14:0] hold_y;
    logic [3:0]  hold_p;

    dac_therm_drv #(.NBITS(4), .RST_CODE(0)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .b       (b),
        .b_valid (b_valid),
        .Y       (y0),
        .y_valid (yv0),
        .ptr     (p0)
    );

    dac_therm_drv #(.NBITS(4), .RST_CODE(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .b       (b),
        .b_valid (b_valid),
        .Y       (y8),
        .y_valid (yv8),
        .ptr     (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference mask: run of `code` ones, rotated left by p within 15 bits.
    function automatic logic [14:0] exp_mask(input logic [3:0] code, input logic [3:0] p);
        logic [29:0] m;
        m = (30'd1 << code) - 30'd1;
        m = m << p;
        return m[14:0] | m[29:15];
    endfunction

    task automatic adv_ptr(input logic [3:0] code);
        if (c_dwa) m_ptr = 4'((5'(m_ptr) + 5'(code)) % 5'd15);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        b_valid = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        m_ptr   = 4'd0;
    endtask

    // Directed rotation / boundary vectors, applied in order from ptr=0.
    logic [3:0]  v_code [5] = '{4'd4, 4'd7, 4'd6, 4'd15, 4'd0};
`ifdef DAC_THERM_DWA_EN
    logic [14:0] v_y    [5] = '{15'h000F, 15'h07F0, 15'h7803, 15'h7FFF, 15'h0000};
    logic [3:0]  v_ptr  [5] = '{4'd4, 4'd11, 4'd2, 4'd2, 4'd2};
`else
    logic [14:0] v_y    [5] = '{15'h000F, 15'h007F, 15'h003F, 15'h7FFF, 15'h0000};
    logic [3:0]  v_ptr  [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`endif

    initial begin
        rst     = 1'b1;
        b       = 4'd0;
        b_valid = 1'b0;
        m_ptr   = 4'd0;

        // ---- 1: reset state and single-code latency ----
        do_reset();
        check("rst_y",     32'(y0),  32'h0000);
        check("rst_yv",    32'(yv0), 32'd0);
        check("rst_ptr",   32'(p0),  32'd0);
        check("rst8_y",    32'(y8),  32'h00FF);
        b = 4'd9; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        check("lat_edge1_yv", 32'(yv0), 32'd0);
        check("lat_edge1_y",  32'(y0),  32'h0000);
        tick();
        check("lat_edge2_y",  32'(y0),  32'h01FF);
        check("lat_edge2_yv", 32'(yv0), 32'd1);
        check("lat_edge2_ptr", 32'(p0), c_dwa ? 32'd9 : 32'd0);
        tick();
        check("lat_pulse_end_yv", 32'(yv0), 32'd0);
        check("lat_hold_y",       32'(y0),  32'h01FF);

        // ---- 2: back-to-back sweep of every code ----
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            b       = 4'(k);
            b_valid = (k < 16);
            tick();
            if (k >= 1) begin
                check($sformatf("sweep_y_c%0d", k - 1), 32'(y0), 32'(exp_mask(4'(k - 1), m_ptr)));
                check($sformatf("sweep_yv_c%0d", k - 1), 32'(yv0), 32'd1);
                check($sformatf("sweep_pop_c%0d", k - 1), 32'($countones(y0)), 32'(k - 1));
                adv_ptr(4'(k - 1));
                check($sformatf("sweep_ptr_c%0d", k - 1), 32'(p0), 32'(m_ptr));
            end
        end
        b_valid = 1'b0;
        tick();
        check("sweep_end_yv", 32'(yv0), 32'd0);

        // ---- 3/4: rotation, wrap-around and boundary codes ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            b = v_code[k]; b_valid = 1'b1;
            tick();
            b_valid = 1'b0;
            tick();
            check($sformatf("dwa_y_%0d", k),   32'(y0),  32'(v_y[k]));
            check($sformatf("dwa_ptr_%0d", k), 32'(p0),  32'(v_ptr[k]));
            check($sformatf("dwa_yv_%0d", k),  32'(yv0), 32'd1);
        end

        // ---- 5: hold during idle cycles with toggling b ----
        do_reset();
        b = 4'd5; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        check("hold_first_y",   32'(y0), 32'h001F);
        check("hold_first_ptr", 32'(p0), c_dwa ? 32'd5 : 32'd0);
        hold_y = 15'h001F;
        hold_p = c_dwa ? 4'd5 : 4'd0;
        for (int k = 0; k < 10; k++) begin
            b = 4'($urandom_range(0, 15));
            tick();
            check($sformatf("hold_y_%0d", k),   32'(y0),  32'(hold_y));
            check($sformatf("hold_yv_%0d", k),  32'(yv0), 32'd0);
            check($sformatf("hold_ptr_%0d", k), 32'(p0),  32'(hold_p));
        end

        // ---- 6: reset with a code in flight ----
        b = 4'd10; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        check("mid_rst_y",   32'(y0),  32'h0000);
        check("mid_rst_ptr", 32'(p0),  32'd0);
        check("mid_rst_yv",  32'(yv0), 32'd0);
        check("mid_rst8_y",  32'(y8),  32'h00FF);
        check("mid_rst8_ptr", 32'(p8), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mid_no_yv_%0d", k),  32'(yv0), 32'd0);
            check($sformatf("mid_no_yv8_%0d", k), 32'(yv8), 32'd0);
            check($sformatf("mid_y8_%0d", k),     32'(y8),  32'h00FF);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
